// File: rtl/dlf_ctrl_pkg.sv
// Shared types and default constants for the ADPLL loop-filter gear controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dlf_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACQ   = 3'd2,
    S_TRACK = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam int ERR_W_DEF         = 8;
  localparam int GEAR_N_DEF        = 4;
  localparam int CLR_CYC_DEF       = 2;
  localparam int DWELL_DEF         = 64;
  localparam int LOCK_THRESH_DEF   = 4;
  localparam int LOCK_CNT_DEF      = 16;
  localparam int UNLOCK_THRESH_DEF = 32;

  // Coefficient bank select for the default bank count.
  typedef logic [$clog2(GEAR_N_DEF)-1:0] gear_t;

endpackage

// File: rtl/dlf_lock_detect.sv
// Lock/unlock detector: counts consecutive small (and, optionally, large) phase errors.
// Latency: hit outputs are combinational on the strobe of the deciding sample.
// Backpressure: none; every strobe is consumed in the cycle it arrives.
// Ports: clk/rstn (sync, active-low); i_clr clears all counters;
//   i_acq_stb = accepted sample in the last ACQ gear; i_trk_stb = accepted sample in TRACK;
//   i_err_mag = magnitude for the strobed sample; o_lock_hit / o_unlock_hit = decision pulses.
// Optional: DLF_LOSS_OF_LOCK_EN adds the 2-bit bad-sample counter behind o_unlock_hit.
module dlf_lock_detect
  import dlf_ctrl_pkg::*;
#(
  parameter int ERR_W         = ERR_W_DEF,
  parameter int LOCK_THRESH   = LOCK_THRESH_DEF,
  parameter int LOCK_CNT      = LOCK_CNT_DEF,
  parameter int UNLOCK_THRESH = UNLOCK_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_acq_stb,
  input  logic             i_trk_stb,
  input  logic [ERR_W-1:0] i_err_mag,
  output logic             o_lock_hit,
  output logic             o_unlock_hit
);

  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] LP_SMALL     = ERR_W'(LOCK_THRESH);
  localparam logic [ERR_W-1:0] LP_LARGE     = ERR_W'(UNLOCK_THRESH);
  localparam logic [LCW-1:0]   LP_LOCK_MAX  = LCW'(LOCK_CNT);
  localparam logic [LCW-1:0]   LP_LOCK_LAST = LCW'(LOCK_CNT - 1);

  logic [LCW-1:0] r_lock_cnt;
  logic           w_small;

  assign w_small = (i_err_mag <= LP_SMALL);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lock_cnt <= '0;
    end else if (i_clr) begin
      r_lock_cnt <= '0;
    end else if (i_acq_stb) begin
      if (!w_small)
        r_lock_cnt <= '0;
      else if (r_lock_cnt != LP_LOCK_MAX)
        r_lock_cnt <= r_lock_cnt + LCW'(1);
    end
  end

  // Fires on the sample that completes the run, so the FSM can move on the same edge.
  assign o_lock_hit = i_acq_stb & w_small & (r_lock_cnt == LP_LOCK_LAST);

`ifdef DLF_LOSS_OF_LOCK_EN
  logic [1:0] r_bad_cnt;
  logic       w_large;

  assign w_large = (i_err_mag >= LP_LARGE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bad_cnt <= 2'd0;
    end else if (i_clr) begin
      r_bad_cnt <= 2'd0;
    end else if (i_trk_stb) begin
      if (!w_large)
        r_bad_cnt <= 2'd0;
      else if (r_bad_cnt != 2'd3)
        r_bad_cnt <= r_bad_cnt + 2'd1;
    end
  end

  // Three large samples already counted plus a fourth one now.
  assign o_unlock_hit = i_trk_stb & w_large & (r_bad_cnt == 2'd3);
`else
  logic w_unused;
  assign w_unused     = i_trk_stb ^ (|LP_LARGE);
  assign o_unlock_hit = 1'b0;
`endif

endmodule

// File: rtl/dlf_gear_controller.sv
// Loop-filter sequencer: drives DLF clear/enable, steps the coefficient gear, declares lock.
// Latency: dlf_ce one cycle after an accepted err_valid; gear step visible two cycles after it.
// Backpressure: none; freeze suspends updates and drops any coincident sample.
// Ports: clk, rstn (sync, active-low); i_start (pulse), i_freeze (level),
//   i_err_valid/i_err_mag (sample strobe + magnitude); o_dlf_ce (update pulse),
//   o_dlf_clr (delay-line clear), o_gear (bank select), o_locked, o_busy. All outputs registered.
// Optional: DLF_LOSS_OF_LOCK_EN enables loss-of-lock re-acquisition from TRACK.
module dlf_gear_controller
  import dlf_ctrl_pkg::*;
#(
  parameter int ERR_W         = ERR_W_DEF,
  parameter int GEAR_N        = GEAR_N_DEF,
  parameter int CLR_CYC       = CLR_CYC_DEF,
  parameter int DWELL         = DWELL_DEF,
  parameter int LOCK_THRESH   = LOCK_THRESH_DEF,
  parameter int LOCK_CNT      = LOCK_CNT_DEF,
  parameter int UNLOCK_THRESH = UNLOCK_THRESH_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_start,
  input  logic                      i_freeze,
  input  logic                      i_err_valid,
  input  logic [ERR_W-1:0]          i_err_mag,
  output logic                      o_dlf_ce,
  output logic                      o_dlf_clr,
  output logic [$clog2(GEAR_N)-1:0] o_gear,
  output logic                      o_locked,
  output logic                      o_busy
);

  localparam int GW = $clog2(GEAR_N);
  localparam int DW = $clog2(DWELL + 1);
  localparam int CW = $clog2(CLR_CYC + 1);
  localparam logic [GW-1:0] LP_GEAR_LAST  = GW'(GEAR_N - 1);
  localparam logic [DW-1:0] LP_DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] LP_CLR_LAST   = CW'(CLR_CYC - 1);

  state_t        r_state, r_ret;
  state_t        w_next, w_ret_next, w_eff;
  logic [CW-1:0] r_clr_cnt;
  logic [DW-1:0] r_dwell;
  logic [GW-1:0] r_gear;
  logic          r_step;
  logic          r_dlf_ce, r_dlf_clr, r_locked, r_busy;

  logic w_accept, w_dwell_stb, w_dwell_done;
  logic w_acq_stb, w_trk_stb, w_lock_clr;
  logic w_lock_hit, w_unlock_hit;

  // HOLD with freeze released behaves as the saved state, so a sample arriving
  // on the release edge is already accepted.
  assign w_eff    = (r_state == S_HOLD) ? r_ret : r_state;
  assign w_accept = i_err_valid & ~i_freeze & ((w_eff == S_ACQ) | (w_eff == S_TRACK));

  assign w_dwell_stb  = w_accept & (w_eff == S_ACQ) & (r_gear != LP_GEAR_LAST);
  assign w_dwell_done = w_dwell_stb & (r_dwell == LP_DWELL_LAST);
  assign w_acq_stb    = w_accept & (w_eff == S_ACQ) & (r_gear == LP_GEAR_LAST);
  assign w_trk_stb    = w_accept & (w_eff == S_TRACK);
  assign w_lock_clr   = (r_state == S_CLEAR) | w_dwell_done;

  dlf_lock_detect #(
    .ERR_W        (ERR_W),
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_CNT     (LOCK_CNT),
    .UNLOCK_THRESH(UNLOCK_THRESH)
  ) u_lock_detect (
    .clk         (clk),
    .rstn        (rstn),
    .i_clr       (w_lock_clr),
    .i_acq_stb   (w_acq_stb),
    .i_trk_stb   (w_trk_stb),
    .i_err_mag   (i_err_mag),
    .o_lock_hit  (w_lock_hit),
    .o_unlock_hit(w_unlock_hit)
  );

  always_comb begin
    w_next     = r_state;
    w_ret_next = r_ret;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_clr_cnt == LP_CLR_LAST) w_next = S_ACQ;
      end
      S_ACQ, S_TRACK, S_HOLD: begin
        if (i_freeze) begin
          w_next = S_HOLD;
          if (r_state != S_HOLD) w_ret_next = r_state;
        end else if ((w_eff == S_ACQ) && w_lock_hit) begin
          w_next = S_TRACK;
        end else if ((w_eff == S_TRACK) && w_unlock_hit) begin
          w_next = S_CLEAR;
        end else begin
          w_next = w_eff;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_ret     <= S_IDLE;
      r_clr_cnt <= '0;
      r_dwell   <= '0;
      r_gear    <= '0;
      r_step    <= 1'b0;
      r_dlf_ce  <= 1'b0;
      r_dlf_clr <= 1'b0;
      r_locked  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ret     <= w_ret_next;
      r_dlf_ce  <= w_accept;
      r_dlf_clr <= (w_next == S_CLEAR);
      r_busy    <= (w_next != S_IDLE);
      if (w_next == S_CLEAR) begin
        r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + CW'(1) : '0;
        r_dwell   <= '0;
        r_gear    <= '0;
        r_step    <= 1'b0;
        r_locked  <= 1'b0;
      end else begin
        r_clr_cnt <= '0;
        // The DWELL-th sample is filtered with the old bank; the step lands one edge later.
        if (r_step) begin
          r_gear <= r_gear + GW'(1);
          r_step <= 1'b0;
        end
        if (w_dwell_done) begin
          r_dwell <= '0;
          r_step  <= 1'b1;
        end else if (w_dwell_stb) begin
          r_dwell <= r_dwell + DW'(1);
        end
        if (w_lock_hit) r_locked <= 1'b1;
      end
    end
  end

  assign o_dlf_ce  = r_dlf_ce;
  assign o_dlf_clr = r_dlf_clr;
  assign o_gear    = r_gear;
  assign o_locked  = r_locked;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_dlf_gear_controller.sv
// Bench for dlf_gear_controller: directed sequence plus randomized traffic against a behavioural model.
// Latency: model predicts outputs one edge after each input set.
// Backpressure: n/a.
module tb_dlf_gear_controller;
  import dlf_ctrl_pkg::*;

  localparam int ERR_W         = 8;
  localparam int GEAR_N        = 4;
  localparam int CLR_CYC       = 2;
  localparam int DWELL         = 64;
  localparam int LOCK_THRESH   = 4;
  localparam int LOCK_CNT      = 16;
  localparam int UNLOCK_THRESH = 32;
  localparam int LAST          = GEAR_N - 1;

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_ACQ   = 2;
  localparam int M_TRACK = 3;

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             start     = 1'b0;
  logic             freeze    = 1'b0;
  logic             err_valid = 1'b0;
  logic [ERR_W-1:0] err_mag   = '0;
  logic             dlf_ce, dlf_clr, locked, busy;
  gear_t            gear;

  int checks = 0;
  int errors = 0;
  int frz_left = 0;

  // Behavioural model state: operating mode, accepted ACQ samples since the last
  // clear, run lengths of small / large errors, and the predicted outputs.
  int m_mode      = M_IDLE;
  int m_clr_seen  = 0;
  int m_n_acq     = 0;
  int m_small_run = 0;
  int m_bad_run   = 0;
  int m_gear      = 0;
  bit m_locked    = 1'b0;
  bit m_ce        = 1'b0;

  always #5 clk = ~clk;

  dlf_gear_controller #(
    .ERR_W(ERR_W), .GEAR_N(GEAR_N), .CLR_CYC(CLR_CYC), .DWELL(DWELL),
    .LOCK_THRESH(LOCK_THRESH), .LOCK_CNT(LOCK_CNT), .UNLOCK_THRESH(UNLOCK_THRESH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_start    (start),
    .i_freeze   (freeze),
    .i_err_valid(err_valid),
    .i_err_mag  (err_mag),
    .o_dlf_ce   (dlf_ce),
    .o_dlf_clr  (dlf_clr),
    .o_gear     (gear),
    .o_locked   (locked),
    .o_busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic enter_clear();
    m_mode      = M_CLEAR;
    m_clr_seen  = 1;
    m_gear      = 0;
    m_n_acq     = 0;
    m_small_run = 0;
    m_bad_run   = 0;
    m_locked    = 1'b0;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    int g_old;
    m_ce = 1'b0;
    if (!rstn) begin
      m_mode = M_IDLE; m_clr_seen = 0; m_n_acq = 0; m_small_run = 0;
      m_bad_run = 0; m_gear = 0; m_locked = 1'b0;
      return;
    end
    case (m_mode)
      M_IDLE:  if (start) enter_clear();
      M_CLEAR: if (m_clr_seen >= CLR_CYC) m_mode = M_ACQ; else m_clr_seen++;
      default: begin
        g_old = m_gear;
        // The bank shown is the count of completed dwells as of the previous edge.
        m_gear = (m_n_acq / DWELL > LAST) ? LAST : m_n_acq / DWELL;
        acc  = err_valid && !freeze;
        m_ce = acc;
        if (acc && m_mode == M_ACQ) begin
          if (g_old < LAST) m_n_acq++;
          else begin
            m_small_run = (int'(err_mag) <= LOCK_THRESH) ? m_small_run + 1 : 0;
            if (m_small_run >= LOCK_CNT) begin
              m_mode = M_TRACK;
              m_locked = 1'b1;
            end
          end
        end else if (acc && m_mode == M_TRACK) begin
`ifdef DLF_LOSS_OF_LOCK_EN
          m_bad_run = (int'(err_mag) >= UNLOCK_THRESH) ? m_bad_run + 1 : 0;
          if (m_bad_run == 4) enter_clear();
`endif
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("busy",    32'(busy),    32'(m_mode != M_IDLE));
    check("dlf_clr", 32'(dlf_clr), 32'(m_mode == M_CLEAR));
    check("dlf_ce",  32'(dlf_ce),  32'(m_ce));
    check("gear",    32'(gear),    32'(m_gear));
    check("locked",  32'(locked),  32'(m_locked));
  endtask

  task automatic send(input int mag, input int gap);
    err_valid = 1'b1;
    err_mag   = ERR_W'(mag);
    tick();
    err_valid = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_gear", 32'(gear), 0);
    check("rst_locked", 32'(locked), 0);
    rstn = 1'b1;
    err_valid = 1'b1;                       // ignored in IDLE
    tick();
    err_valid = 1'b0;
    check("idle_ce", 32'(dlf_ce), 0);

    // Start: clear held for two cycles, then acquisition at gear 0
    start = 1'b1; tick(); start = 1'b0;
    check("clr_c1", 32'(dlf_clr), 1);
    tick();
    check("clr_c2", 32'(dlf_clr), 1);
    tick();
    check("clr_off", 32'(dlf_clr), 0);
    check("acq_busy", 32'(busy), 1);

    // Dwell through gears 0..2 with large errors
    for (int i = 0; i < 3 * DWELL; i++) begin
      send(int'($urandom_range(50, 255)), (i % DWELL == DWELL - 1) ? 2 : int'($urandom_range(1, 3)));
      if (i == DWELL - 1) check("gear_step1", 32'(gear), 1);
    end
    check("gear_last", 32'(gear), 3);
    check("no_lock_acq", 32'(locked), 0);

    // Lock search: a run of 15 broken by a 5, then 16 small samples
    for (int i = 0; i < 15; i++) send(4, 1);
    send(5, 1);
    check("lock_broken", 32'(locked), 0);
    for (int i = 0; i < 16; i++) send(3, (i == 15) ? 0 : 1);
    check("lock_set", 32'(locked), 1);
    tick();

    // Freeze in TRACK with samples toggling, including a coincident strobe
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      err_valid = (i % 2 == 0);
      err_mag   = 8'd2;
      tick();
      check("frz_ce", 32'(dlf_ce), 0);
    end
    freeze = 1'b0; err_valid = 1'b0;
    tick();
    err_valid = 1'b1; err_mag = 8'd7;
    tick();
    check("resume_ce", 32'(dlf_ce), 1);
    err_valid = 1'b0;
    tick();
    check("frz_gear", 32'(gear), 3);

    // Loss-of-lock pattern
    for (int i = 0; i < 3; i++) send(32, 1);
    send(10, 1);
    check("lol_pre", 32'(locked), 1);
    for (int i = 0; i < 4; i++) send(40, (i == 3) ? 0 : 1);
`ifdef DLF_LOSS_OF_LOCK_EN
    check("lol_locked", 32'(locked), 0);
    check("lol_clr", 32'(dlf_clr), 1);
`else
    check("lol_locked", 32'(locked), 1);
    check("lol_clr", 32'(dlf_clr), 0);
`endif
    tick();

    // Reset mid-acquisition at gear 2
    rstn = 1'b0; tick(); rstn = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2 * DWELL + 5; i++) send(int'($urandom_range(0, 255)), 1);
    tick();
    check("pre_rst_gear", 32'(gear), 2);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_gear", 32'(gear), 0);
    for (int i = 0; i < 4; i++) send(1, 1);
    check("need_start", 32'(busy), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rstn  = ($urandom_range(0, 999) != 0);
      start = ($urandom_range(0, 59) == 0);
      if (frz_left > 0) begin
        freeze = 1'b1;
        frz_left--;
      end else begin
        freeze = 1'b0;
        if ($urandom_range(0, 39) == 0) frz_left = int'($urandom_range(1, 8));
      end
      err_valid = ($urandom_range(0, 2) == 0);
      if (m_locked && $urandom_range(0, 1) == 0)
        err_mag = ERR_W'($urandom_range(UNLOCK_THRESH - 1, 255));
      else if ($urandom_range(0, 9) < 7)
        err_mag = ERR_W'($urandom_range(0, LOCK_THRESH + 1));
      else
        err_mag = ERR_W'($urandom_range(0, 255));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
